min_sum_iter_engine: RTL and testbench

//  Iterative min-sum LDPC decoder core. Time-multiplexes one variable_nodes + check_nodes layer

---
 rtl/min_sum_iter_engine.sv | 192 +++++++++++++++++++
 tb/tb_min_sum_iter_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/min_sum_iter_engine.sv
// Iterative min-sum LDPC decoder core: one variable/check layer pair reused every iteration,
// edge messages held in a register between iterations, early stop on a zero syndrome.
module min_sum_iter_engine #(
  parameter int N_V       = 44,
  parameter int N_C       = 12,
  parameter int E         = 147,
  parameter int N_FP      = 8,
  parameter int MAX_ITER  = 8,
  parameter int LAYER_LAT = 0,
  parameter int IW        = $clog2(MAX_ITER + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [E-1:0][E-1:0]           adj_matrix_odd,
  input  logic [E-1:0][E-1:0]           adj_matrix_even,
  input  logic [N_V-1:0][E-1:0]         adj_matrix_in,
  input  logic [N_C-1:0][N_V-1:0]       h_matrix,
  input  logic [N_V-1:0][N_FP-1:0]      llr_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IW-1:0]                 iter_limit,
  input  logic                          early_stop_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_V-1:0]                hard_bits,
  output logic [IW-1:0]                 iter_count,
  output logic                          converged
);
  localparam int ACC_W = N_FP + $clog2(E) + 1;
  localparam int CW    = (LAYER_LAT > 0) ? $clog2(LAYER_LAT + 1) : 1;
  localparam logic signed [ACC_W-1:0] MSG_MAX = ACC_W'((2 ** (N_FP - 1)) - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  typedef logic [N_FP-1:0] msg_t;

  function automatic logic signed [ACC_W-1:0] sext(input msg_t x);
    return {{(ACC_W - N_FP){x[N_FP-1]}}, x};
  endfunction

  // Symmetric saturation keeps -MAX representable as a magnitude in the check layer.
  function automatic msg_t sat(input logic signed [ACC_W-1:0] x);
    if (x > MSG_MAX)  return MSG_MAX[N_FP-1:0];
    if (x < -MSG_MAX) return msg_t'(-MSG_MAX);
    return x[N_FP-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         iter_q, iter_d, limit_q, limit_d;
  logic                  es_q, es_d;
  msg_t [N_V-1:0]        llr_q, llr_d;
  msg_t [E-1:0]          msg_q, msg_d;
  logic [N_V-1:0]        hard_bits_q, hard_bits_d;
  logic [IW-1:0]         iter_count_q, iter_count_d;
  logic                  converged_q, converged_d;

  msg_t [E-1:0]          v2c, c2v;
  logic [N_V-1:0]        hb;
  logic [N_C-1:0]        syn;

  // Variable layer: channel LLR plus every other incoming check message on the same node.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    v2c = '0;
    acc = '0;
    for (int e = 0; e < E; e++) begin
      acc = '0;
      for (int v = 0; v < N_V; v++)
        if (adj_matrix_in[v][e]) acc = acc + sext(llr_q[v]);
      for (int f = 0; f < E; f++)
        if (adj_matrix_odd[e][f]) acc = acc + sext(msg_q[f]);
      v2c[e] = sat(acc);
    end
  end

  // Check layer: sign product and minimum magnitude over the other edges of the check.
  always_comb begin
    logic sgn, any;
    msg_t mag, mn;
    c2v = '0;
    sgn = 1'b0;
    any = 1'b0;
    mag = '0;
    mn  = '0;
    for (int e = 0; e < E; e++) begin
      sgn = 1'b0;
      any = 1'b0;
      mn  = MSG_MAX[N_FP-1:0];
      for (int f = 0; f < E; f++) begin
        if (adj_matrix_even[e][f]) begin
          any = 1'b1;
          sgn = sgn ^ v2c[f][N_FP-1];
          mag = v2c[f][N_FP-1] ? -v2c[f] : v2c[f];
          if (mag < mn) mn = mag;
        end
      end
      if (any) c2v[e] = sgn ? -mn : mn;
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] tot;
    hb  = '0;
    syn = '0;
    tot = '0;
    for (int v = 0; v < N_V; v++) begin
      tot = sext(llr_q[v]);
      for (int e = 0; e < E; e++)
        if (adj_matrix_in[v][e]) tot = tot + sext(msg_q[e]);
      hb[v] = tot[ACC_W-1];
    end
    for (int c = 0; c < N_C; c++)
      syn[c] = ^(h_matrix[c] & hb);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    iter_d       = iter_q;
    limit_d      = limit_q;
    es_d         = es_q;
    llr_d        = llr_q;
    msg_d        = msg_q;
    hard_bits_d  = hard_bits_q;
    iter_count_d = iter_count_q;
    converged_d  = converged_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        llr_d   = llr_in;
        es_d    = early_stop_en;
        limit_d = (iter_limit == '0 || iter_limit > IW'(MAX_ITER)) ? IW'(MAX_ITER) : iter_limit;
        msg_d   = '0;
        iter_d  = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (cnt_q == CW'(LAYER_LAT)) begin
        msg_d   = c2v;
        iter_d  = iter_q + 1'b1;
        cnt_d   = '0;
        state_d = CHECK;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      CHECK: if ((es_q && syn == '0) || iter_q == limit_q) begin
        hard_bits_d  = hb;
        iter_count_d = iter_q;
        converged_d  = (syn == '0);
        state_d      = DONE;
      end else begin
        state_d = RUN;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      iter_q       <= '0;
      limit_q      <= '0;
      es_q         <= 1'b0;
      // NOTE: LLR and message arrays are cleared too, so an aborted frame leaves no residue.
      llr_q        <= '0;
      msg_q        <= '0;
      hard_bits_q  <= '0;
      iter_count_q <= '0;
      converged_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      iter_q       <= iter_d;
      limit_q      <= limit_d;
      es_q         <= es_d;
      llr_q        <= llr_d;
      msg_q        <= msg_d;
      hard_bits_q  <= hard_bits_d;
      iter_count_q <= iter_count_d;
      converged_q  <= converged_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign hard_bits  = hard_bits_q;
  assign iter_count = iter_count_q;
  assign converged  = converged_q;
endmodule

// File: tb/tb_min_sum_iter_engine.sv
// Directed bench for min_sum_iter_engine on a small irregular 12x44 code with 147 edges.
// Variable 3 sits alone on checks 0..2; every other variable touches exactly one of those checks.
module tb_min_sum_iter_engine;
  localparam int N_V = 44, N_C = 12, E = 147, N_FP = 8, MAX_ITER = 8, IW = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [E-1:0][E-1:0]      adj_odd, adj_even;
  logic [N_V-1:0][E-1:0]    adj_in;
  logic [N_C-1:0][N_V-1:0]  h;
  logic [N_V-1:0][N_FP-1:0] llr_in;
  logic                     in_valid, in_ready, early_stop_en, out_valid, out_ready, converged;
  logic [IW-1:0]            iter_limit, iter_count;
  logic [N_V-1:0]           hard_bits;

  int checks = 0;
  int errors = 0;
  int edge_var[E];
  int edge_chk[E];

  always #5 clk = ~clk;

  min_sum_iter_engine #(.N_V(N_V), .N_C(N_C), .E(E), .N_FP(N_FP), .MAX_ITER(MAX_ITER), .LAYER_LAT(0)) dut (
    .clk(clk), .rst(rst),
    .adj_matrix_odd(adj_odd), .adj_matrix_even(adj_even), .adj_matrix_in(adj_in), .h_matrix(h),
    .llr_in(llr_in), .in_valid(in_valid), .in_ready(in_ready),
    .iter_limit(iter_limit), .early_stop_en(early_stop_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .hard_bits(hard_bits), .iter_count(iter_count), .converged(converged)
  );

  task automatic build_graph();
    int e;
    int nchk;
    int chk[4];
    e = 0;
    adj_odd = '0; adj_even = '0; adj_in = '0; h = '0;
    for (int v = 0; v < N_V; v++) begin
      if (v == 3) begin
        chk[0] = 0; chk[1] = 1; chk[2] = 2; chk[3] = 0; nchk = 3;
      end else begin
        chk[0] = v % 3; chk[1] = 3 + v % 9; chk[2] = 3 + (v + 4) % 9; chk[3] = 3 + (v + 2) % 9;
        nchk = (v >= 29) ? 4 : 3;
      end
      for (int k = 0; k < nchk; k++) begin
        edge_var[e] = v; edge_chk[e] = chk[k];
        adj_in[v][e] = 1'b1; h[chk[k]][v] = 1'b1;
        e++;
      end
    end
    for (int a = 0; a < E; a++)
      for (int b = 0; b < E; b++)
        if (a != b) begin
          if (edge_var[a] == edge_var[b]) adj_odd[a][b] = 1'b1;
          if (edge_chk[a] == edge_chk[b]) adj_even[a][b] = 1'b1;
        end
  endtask

  task automatic set_llr(input int base, input int idx, input int val);
    for (int v = 0; v < N_V; v++) llr_in[v] = N_FP'(base);
    llr_in[idx] = N_FP'(val);
  endtask

  // Latency counts the accept cycle as 1; DUT must be in IDLE on entry.
  task automatic run_frame(input int limit, input logic es, output int lat);
    iter_limit = IW'(limit); early_stop_en = es; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_timeout out_valid got %b exp 1 after %0d cycles", out_valid, lat); end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; iter_limit = '0; early_stop_en = 1'b0;
    set_llr(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (hard_bits !== '0) begin errors++; $display("FAIL rst_hard_bits got %h exp 0", hard_bits); end
    checks++; if (iter_count !== 4'd0) begin errors++; $display("FAIL rst_iter_count got %0d exp 0", iter_count); end
    checks++; if (converged !== 1'b0) begin errors++; $display("FAIL rst_converged got %b exp 0", converged); end
  endtask

  task automatic test_zero_codeword();
    int lat;
    set_llr(20, 0, 20);
    run_frame(5, 1'b1, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency got %0d exp 3", lat); end
    checks++; if (hard_bits !== '0) begin errors++; $display("FAIL zero_hard_bits got %h exp 0", hard_bits); end
    checks++; if (iter_count !== 4'd1) begin errors++; $display("FAIL zero_iter_count got %0d exp 1", iter_count); end
    checks++; if (converged !== 1'b1) begin errors++; $display("FAIL zero_converged got %b exp 1", converged); end
    handshake();
  endtask

  task automatic test_no_early_stop();
    int lat;
    set_llr(20, 0, 20);
    run_frame(5, 1'b0, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL noes_latency got %0d exp 11", lat); end
    checks++; if (hard_bits !== '0) begin errors++; $display("FAIL noes_hard_bits got %h exp 0", hard_bits); end
    checks++; if (iter_count !== 4'd5) begin errors++; $display("FAIL noes_iter_count got %0d exp 5", iter_count); end
    checks++; if (converged !== 1'b1) begin errors++; $display("FAIL noes_converged got %b exp 1", converged); end
    handshake();
  endtask

  // Variable 3 flipped weakly: its three checks pull it back to +40 in the first iteration.
  task automatic test_single_error();
    int lat;
    set_llr(20, 3, -20);
    run_frame(8, 1'b1, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL serr_latency got %0d exp 3", lat); end
    checks++; if (hard_bits !== '0) begin errors++; $display("FAIL serr_hard_bits got %h exp 0", hard_bits); end
    checks++; if (iter_count !== 4'd1) begin errors++; $display("FAIL serr_iter_count got %0d exp 1", iter_count); end
    checks++; if (converged !== 1'b1) begin errors++; $display("FAIL serr_converged got %b exp 1", converged); end
    handshake();
  endtask

  // Strong error on variable 3: total -100+3*20 = -40 stays negative, checks 0..2 fail.
  task automatic test_no_converge();
    int lat;
    set_llr(20, 3, -100);
    run_frame(1, 1'b1, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL nconv_latency got %0d exp 3", lat); end
    checks++; if (hard_bits !== 44'h8) begin errors++; $display("FAIL nconv_hard_bits got %h exp 8", hard_bits); end
    checks++; if (iter_count !== 4'd1) begin errors++; $display("FAIL nconv_iter_count got %0d exp 1", iter_count); end
    checks++; if (converged !== 1'b0) begin errors++; $display("FAIL nconv_converged got %b exp 0", converged); end
    handshake();
  endtask

  task automatic test_clamp();
    int lat;
    int lims[2] = '{0, 15};
    set_llr(20, 0, 20);
    foreach (lims[i]) begin
      run_frame(lims[i], 1'b0, lat);
      checks++; if (lat != 17) begin errors++; $display("FAIL clamp_latency lim %0d got %0d exp 17", lims[i], lat); end
      checks++; if (iter_count !== 4'd8) begin errors++; $display("FAIL clamp_iter_count lim %0d got %0d exp 8", lims[i], iter_count); end
      checks++; if (converged !== 1'b1) begin errors++; $display("FAIL clamp_converged lim %0d got %b exp 1", lims[i], converged); end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_llr(20, 3, -100);
    run_frame(1, 1'b1, lat);
    set_llr(20, 0, 20);
    iter_limit = 4'd5; early_stop_en = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b exp 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", c, in_ready); end
      checks++; if (hard_bits !== 44'h8) begin errors++; $display("FAIL bp_hard_bits cyc %0d got %h exp 8", c, hard_bits); end
      checks++; if (iter_count !== 4'd1) begin errors++; $display("FAIL bp_iter_count cyc %0d got %0d exp 1", c, iter_count); end
      checks++; if (converged !== 1'b0) begin errors++; $display("FAIL bp_converged cyc %0d got %b exp 0", c, converged); end
    end
    handshake();
    checks++; if (hard_bits !== 44'h8) begin errors++; $display("FAIL idle_hold_hard_bits got %h exp 8", hard_bits); end
    checks++; if (iter_count !== 4'd1) begin errors++; $display("FAIL idle_hold_iter_count got %0d exp 1", iter_count); end
    run_frame(5, 1'b1, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL b2b_latency got %0d exp 3", lat); end
    checks++; if (hard_bits !== '0) begin errors++; $display("FAIL b2b_hard_bits got %h exp 0", hard_bits); end
    checks++; if (converged !== 1'b1) begin errors++; $display("FAIL b2b_converged got %b exp 1", converged); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    set_llr(20, 0, 20);
    iter_limit = 4'd5; early_stop_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready got %b exp 1", in_ready); end
    checks++; if (iter_count !== 4'd0) begin errors++; $display("FAIL mrst_iter_count got %0d exp 0", iter_count); end
    checks++; if (converged !== 1'b0) begin errors++; $display("FAIL mrst_converged got %b exp 0", converged); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_no_output got %b exp 0", out_valid); end
    run_frame(5, 1'b1, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL mrst_latency got %0d exp 3", lat); end
    checks++; if (hard_bits !== '0) begin errors++; $display("FAIL mrst_hard_bits got %h exp 0", hard_bits); end
    checks++; if (iter_count !== 4'd1) begin errors++; $display("FAIL mrst_frame_iter got %0d exp 1", iter_count); end
    checks++; if (converged !== 1'b1) begin errors++; $display("FAIL mrst_frame_conv got %b exp 1", converged); end
    handshake();
  endtask

  initial begin
    build_graph();
    test_reset();
    test_zero_codeword();
    test_no_early_stop();
    test_single_error();
    test_no_converge();
    test_clamp();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
